// File: rtl/reversi_accel_mac_pipe.sv
// Pipelined multiply-accumulate for the reversi_accel evaluation datapath.
// Define REVERSI_ACCEL_MAC_SAT_EN to clamp overflowing accumulations instead of wrapping.
module reversi_accel_mac_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 12,
  parameter int A_SIGNED  = 1,
  parameter int B_SIGNED  = 1,
  parameter int NUM_STAGE = 4,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  input  logic                 acc_en,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 ovf
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int RT      = NUM_STAGE - 2;
  localparam int MSB     = ACC_WIDTH - 1;
  localparam bit SIGNED_MODE = (A_SIGNED != 0) || (B_SIGNED != 0);

  logic [A_WIDTH-1:0]   a1;
  logic [B_WIDTH-1:0]   b1;
  logic                 v1, acc1, last1;

  logic [P_WIDTH-1:0]   a_w, b_w, prod;
  logic [ACC_WIDTH-1:0] ext_c;

  logic [ACC_WIDTH-1:0] ext_q [RT];
  logic [RT-1:0]        v_q, acc_q_s, last_q;

  logic [ACC_WIDTH-1:0] ext_t, base, acc_val;
  logic                 v_t, acc_t, last_t;
  logic [ACC_WIDTH:0]   sum_w;
  logic                 s_ovr, ovr;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 first_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a1    <= '0;
      b1    <= '0;
      v1    <= 1'b0;
      acc1  <= 1'b0;
      last1 <= 1'b0;
    end else if (ce) begin
      a1    <= din0;
      b1    <= din1;
      v1    <= in_valid;
      acc1  <= acc_en;
      last1 <= in_last;
    end
  end

  // Operands are extended to the full product width so the truncated product is exact.
  always_comb begin
    a_w   = {{B_WIDTH{(A_SIGNED != 0) && a1[A_WIDTH-1]}}, a1};
    b_w   = {{A_WIDTH{(B_SIGNED != 0) && b1[B_WIDTH-1]}}, b1};
    prod  = a_w * b_w;
    ext_c = {ACC_WIDTH{SIGNED_MODE && prod[P_WIDTH-1]}};
    ext_c[P_WIDTH-1:0] = prod;
  end

  // ext_q[0] is the multiply stage; the rest are retiming registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RT; i++) ext_q[i] <= '0;
      v_q     <= '0;
      acc_q_s <= '0;
      last_q  <= '0;
    end else if (ce) begin
      ext_q[0]   <= ext_c;
      v_q[0]     <= v1;
      acc_q_s[0] <= acc1;
      last_q[0]  <= last1;
      for (int i = 1; i < RT; i++) begin
        ext_q[i]   <= ext_q[i-1];
        v_q[i]     <= v_q[i-1];
        acc_q_s[i] <= acc_q_s[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  always_comb begin
    ext_t  = ext_q[RT-1];
    v_t    = v_q[RT-1];
    acc_t  = acc_q_s[RT-1];
    last_t = last_q[RT-1];
    base   = first_q ? '0 : acc_q;
    sum_w  = {1'b0, base} + {1'b0, ext_t};
    s_ovr  = (base[MSB] == ext_t[MSB]) && (sum_w[MSB] != base[MSB]);
    ovr    = SIGNED_MODE ? s_ovr : sum_w[ACC_WIDTH];
`ifdef REVERSI_ACCEL_MAC_SAT_EN
    if (ovr)
      acc_val = SIGNED_MODE ? {base[MSB], {(ACC_WIDTH-1){~base[MSB]}}} : {ACC_WIDTH{1'b1}};
    else
      acc_val = sum_w[ACC_WIDTH-1:0];
`else
    acc_val = sum_w[ACC_WIDTH-1:0];
`endif
  end

  // dout and the running accumulator always hold the same value, so one register serves both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      first_q   <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= v_t;
      out_last  <= v_t & last_t;
      ovf       <= v_t & acc_t & ovr;
      if (v_t) begin
        acc_q   <= acc_t ? acc_val : ext_t;
        first_q <= acc_t ? last_t : (first_q | last_t);
      end
    end
  end

  assign dout = acc_q;

endmodule

// File: tb/tb_reversi_accel_mac_pipe.sv
// Bench for reversi_accel_mac_pipe: signed default instance plus an unsigned instance on the same stimulus.
module tb_reversi_accel_mac_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] din0 = '0;
  logic [11:0] din1 = '0;
  logic        acc_en = 1'b0;
  logic        in_last = 1'b0;

  logic        out_valid, out_last, ovf;
  logic [31:0] dout;
  logic        u_out_valid, u_out_last, u_ovf;
  logic [31:0] u_dout;

  always #5 clk = ~clk;

  reversi_accel_mac_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_en(acc_en), .in_last(in_last),
    .out_valid(out_valid), .out_last(out_last), .dout(dout), .ovf(ovf)
  );

  reversi_accel_mac_pipe #(.A_SIGNED(0), .B_SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_en(acc_en), .in_last(in_last),
    .out_valid(u_out_valid), .out_last(u_out_last), .dout(u_dout), .ovf(u_ovf)
  );

  localparam int LAT = 4;

  typedef struct {
    bit          v;
    bit          last;
    bit          ovf;
    logic [31:0] d;
    bit          uovf;
    logic [31:0] ud;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    bit          last;
    bit          ovf;
    logic [31:0] ud;
    int          cyc;
  } obs_t;

  typedef struct {
    logic [15:0] a;
    logic [11:0] b;
    bit          ac;
    bit          la;
    logic [31:0] d;
    bit          el;
    bit          eo;
  } vec_t;

  int     nvec = 0;
  int     nerr = 0;
  int     cyc = 0;
  exp_t   q[$];
  exp_t   held;
  obs_t   obs[$];
  longint s_acc, u_acc;
  bit     s_first, u_first;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference accumulator: true sum compared against the representable range.
  function automatic void model_upd(input bit ac, input bit la, input longint p, input bit sgn,
                                    inout longint accv, inout bit first, output bit o);
    longint lo, hi, sum;
    lo = sgn ? -(64'sd1 <<< 31) : 64'sd0;
    hi = sgn ? (64'sd1 <<< 31) - 1 : (64'sd1 <<< 32) - 1;
    o  = 1'b0;
    if (!ac) begin
      accv = p;
    end else begin
      sum = (first ? 64'sd0 : accv) + p;
      if (sum < lo || sum > hi) begin
        o = 1'b1;
`ifdef REVERSI_ACCEL_MAC_SAT_EN
        sum = (sum < lo) ? lo : hi;
`else
        sum = ((sum - lo) & 64'sh0000_0000_FFFF_FFFF) + lo;
`endif
      end
      accv  = sum;
      first = 1'b0;
    end
    if (la) first = 1'b1;
  endfunction

  function automatic exp_t model(input bit v, input logic [15:0] a, input logic [11:0] b,
                                 input bit ac, input bit la);
    exp_t   e;
    longint sp, up, sa, sb, ua, ub;
    bit     so, uo;
    so = 1'b0;
    uo = 1'b0;
    if (v) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      sp = sa * sb;
      up = ua * ub;
      model_upd(ac, la, sp, 1'b1, s_acc, s_first, so);
      model_upd(ac, la, up, 1'b0, u_acc, u_first, uo);
    end
    e.v    = v;
    e.last = v & la;
    e.ovf  = so;
    e.uovf = uo;
    e.d    = s_acc[31:0];
    e.ud   = u_acc[31:0];
    return e;
  endfunction

  function automatic exp_t bubble0();
    exp_t e;
    e.v = 1'b0; e.last = 1'b0; e.ovf = 1'b0; e.uovf = 1'b0;
    e.d = '0; e.ud = '0;
    return e;
  endfunction

  task automatic step(input bit v, input logic [15:0] a, input logic [11:0] b,
                      input bit ac, input bit la, input bit cen);
    obs_t o;
    @(negedge clk);
    in_valid = v; din0 = a; din1 = b; acc_en = ac; in_last = la; ce = cen;
    @(posedge clk);
    #1;
    cyc++;
    if (cen) begin
      q.push_back(model(v, a, b, ac, la));
      held = q.pop_front();
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, held.v});
    chk("out_last",  {31'b0, out_last},  {31'b0, held.last});
    chk("ovf",       {31'b0, ovf},       {31'b0, held.ovf});
    chk("dout",      dout,               held.d);
    chk("u_out_valid", {31'b0, u_out_valid}, {31'b0, held.v});
    chk("u_out_last",  {31'b0, u_out_last},  {31'b0, held.last});
    chk("u_ovf",       {31'b0, u_ovf},       {31'b0, held.uovf});
    chk("u_dout",      u_dout,               held.ud);
    if (out_valid && cen) begin
      o.d = dout; o.last = out_last; o.ovf = ovf; o.ud = u_dout; o.cyc = cyc;
      obs.push_back(o);
    end
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; ce = 1'b0; in_valid = 1'b0; acc_en = 1'b0; in_last = 1'b0;
    #2;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_last",  {31'b0, out_last},  32'd0);
    chk("rst ovf",       {31'b0, ovf},       32'd0);
    chk("rst dout",      dout,               32'd0);
    chk("rst u_dout",    u_dout,             32'd0);
    q.delete();
    obs.delete();
    for (int i = 0; i < LAT - 1; i++) q.push_back(bubble0());
    held    = bubble0();
    s_acc   = 0;
    u_acc   = 0;
    s_first = 1'b1;
    u_first = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl[5];

  initial begin
    int c0, nobs;
    logic [15:0] ra;
    logic [11:0] rb;

    tbl[0] = '{16'hFED4, 12'd25,  1'b0, 1'b0, 32'hFFFFE2B4, 1'b0, 1'b0};
    tbl[1] = '{16'd100,  12'd10,  1'b1, 1'b0, 32'd1000,     1'b0, 1'b0};
    tbl[2] = '{16'hFFCE, 12'd4,   1'b1, 1'b0, 32'd800,      1'b0, 1'b0};
    tbl[3] = '{16'd7,    12'hFFD, 1'b1, 1'b1, 32'd779,      1'b1, 1'b0};
    tbl[4] = '{16'd2,    12'd2,   1'b1, 1'b0, 32'd4,        1'b0, 1'b0};

    // Table stream, back-to-back
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, tbl[i].a, tbl[i].b, tbl[i].ac, tbl[i].la, 1'b1);
    bubbles(5);
    nobs = obs.size();
    chk("tbl count", nobs, 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < obs.size()) begin
        chk("tbl dout", obs[i].d, tbl[i].d);
        chk("tbl last", {31'b0, obs[i].last}, {31'b0, tbl[i].el});
        chk("tbl ovf",  {31'b0, obs[i].ovf},  {31'b0, tbl[i].eo});
        chk("tbl back-to-back", obs[i].cyc - obs[0].cyc, i);
      end
    end

    // Single pass-through beat: latency and one-cycle pulse
    do_reset();
    step(1'b1, 16'hFED4, 12'd25, 1'b0, 1'b0, 1'b1);
    c0 = cyc;
    bubbles(6);
    nobs = obs.size();
    chk("pt count", nobs, 32'd1);
    if (obs.size() > 0) begin
      chk("pt latency", obs[0].cyc - c0, LAT - 1);
      chk("pt dout", obs[0].d, 32'hFFFFE2B4);
      chk("pt ovf", {31'b0, obs[0].ovf}, 32'd0);
    end

    // ce stall of 3 cycles after the second beat
    do_reset();
    step(1'b1, 16'd100, 12'd10, 1'b1, 1'b0, 1'b1);
    c0 = cyc;
    step(1'b1, 16'hFFCE, 12'd4, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1234, 12'h567, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd7, 12'hFFD, 1'b1, 1'b1, 1'b1);
    bubbles(6);
    nobs = obs.size();
    chk("stall count", nobs, 32'd3);
    if (obs.size() == 3) begin
      chk("stall d0", obs[0].d, 32'd1000);
      chk("stall d1", obs[1].d, 32'd800);
      chk("stall d2", obs[2].d, 32'd779);
      chk("stall last0", {31'b0, obs[0].last}, 32'd0);
      chk("stall last2", {31'b0, obs[2].last}, 32'd1);
      chk("stall third arrival", obs[2].cyc - c0, 32'd8);
    end

    // Overflow at the 32nd accumulation of 2^26
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 16'h8000, 12'h800, 1'b1, 1'b0, 1'b1);
    bubbles(4);
    nobs = obs.size();
    chk("ovf count", nobs, 32'd32);
    if (obs.size() == 32) begin
      chk("ovf b31 dout", obs[30].d, 32'h7C000000);
      chk("ovf b31 flag", {31'b0, obs[30].ovf}, 32'd0);
`ifdef REVERSI_ACCEL_MAC_SAT_EN
      chk("ovf b32 dout", obs[31].d, 32'h7FFFFFFF);
`else
      chk("ovf b32 dout", obs[31].d, 32'h80000000);
`endif
      chk("ovf b32 flag", {31'b0, obs[31].ovf}, 32'd1);
      chk("ovf unsigned b32", obs[31].ud, 32'h80000000);
    end

    // Reset mid-operation: one result out, two in flight
    do_reset();
    step(1'b1, 16'd5, 12'd5, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'd6, 12'd6, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'd7, 12'd7, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'd0, 12'd0, 1'b0, 1'b0, 1'b1);
    chk("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
    do_reset();
    bubbles(6);
    nobs = obs.size();
    chk("post-reset no output", nobs, 32'd0);
    step(1'b1, 16'd3, 12'd3, 1'b1, 1'b0, 1'b1);
    bubbles(4);
    nobs = obs.size();
    chk("post-reset count", nobs, 32'd1);
    if (obs.size() > 0) chk("post-reset dout", obs[0].d, 32'd9);

    // Unsigned instance, maximal operands
    do_reset();
    step(1'b1, 16'hFFFF, 12'hFFF, 1'b0, 1'b0, 1'b1);
    bubbles(4);
    nobs = obs.size();
    chk("unsigned count", nobs, 32'd1);
    if (obs.size() > 0) chk("unsigned dout", obs[0].ud, 32'h0FFEF001);

    // Randomised traffic against the reference model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'h8000;
        1:       ra = 16'h7FFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 12'h800;
        1:       rb = 12'h7FF;
        default: rb = 12'($urandom);
      endcase
      step($urandom_range(0, 9) < 8, ra, rb, $urandom_range(0, 9) < 8,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 8);
    end
    bubbles(5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
